// File: rtl/alu_pkg.sv
// Shared ALU control codes and multiply-sequencer state encoding.
// Imported by the sequencer and by the top level that owns the ALU mux.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared single-cycle ALU,
// issuing one ADD or SHL per cycle and returning the low XLEN product bits.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0] mplier_reg, mplier_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          mcand_next  = op_a;
          mplier_next = op_b;
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = (op_a == '0 || op_b == '0) ? ST_DONE : ST_ADD;
        end
      end
      ST_ADD: begin
        if (mplier_reg[0]) acc_next = alu_result;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The multiplier shift is local; only the multiplicand goes through the ALU.
        mcand_next  = alu_result;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST || (EARLY_EXIT && (mplier_reg >> 1) == '0))
          state_next = ST_DONE;
        else
          state_next = ST_ADD;
      end
      default: begin
        if (resp_ready) state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    req_ready   = (state_reg == ST_IDLE);
    resp_valid  = (state_reg == ST_DONE);
    resp_result = resp_valid ? acc_reg : '0;
    alu_own     = (state_reg == ST_ADD) || (state_reg == ST_SHIFT);
    alu_srca    = '0;
    alu_srcb    = '0;
    alu_ctrl    = ALU_ADD;
    // Idle ALU inputs are forced to zero so the top-level mux sees a quiet bus.
    if (state_reg == ST_ADD) begin
      alu_srca = acc_reg;
      alu_srcb = mcand_reg;
      alu_ctrl = ALU_ADD;
    end else if (state_reg == ST_SHIFT) begin
      alu_srca = mcand_reg;
      alu_srcb = XLEN'(1);
      alu_ctrl = ALU_SHL;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: one early-exit and one full-length unit, each
// beside a behavioural ALU, checked against a plain-arithmetic product/latency model.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [1:0]  alu_own;
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [31:0] resp_result [2];
  logic [31:0] alu_srca [2];
  logic [31:0] alu_srcb [2];
  logic [31:0] alu_result [2];
  logic [2:0]  alu_ctrl [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Unit 0 exits early, unit 1 always runs all XLEN iterations.
  for (genvar gi = 0; gi < 2; gi++) begin : g_unit
    alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(gi == 0)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .op_a       (op_a[gi]),
      .op_b       (op_b[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_ready (resp_ready[gi]),
      .resp_result(resp_result[gi]),
      .alu_own    (alu_own[gi]),
      .alu_srca   (alu_srca[gi]),
      .alu_srcb   (alu_srcb[gi]),
      .alu_ctrl   (alu_ctrl[gi]),
      .alu_result (alu_result[gi])
    );

    always_comb begin
      case (alu_ctrl[gi])
        ALU_ADD: alu_result[gi] = alu_srca[gi] + alu_srcb[gi];
        ALU_SHL: alu_result[gi] = alu_srca[gi] << alu_srcb[gi][4:0];
        ALU_SUB: alu_result[gi] = alu_srca[gi] - alu_srcb[gi];
        ALU_XOR: alu_result[gi] = alu_srca[gi] ^ alu_srcb[gi];
        ALU_SHR: alu_result[gi] = alu_srca[gi] >> alu_srcb[gi][4:0];
        ALU_OR:  alu_result[gi] = alu_srca[gi] | alu_srcb[gi];
        ALU_AND: alu_result[gi] = alu_srca[gi] & alu_srcb[gi];
        default: alu_result[gi] = '0;
      endcase
    end
  end

  function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  // Number of ADD/SHL pairs the sequencer is expected to spend on this request.
  function automatic int model_iters(input int u, input logic [31:0] a, input logic [31:0] b);
    if (a == 0 || b == 0) return 0;
    if (u == 1) return 32;
    for (int i = 31; i >= 0; i--)
      if (b[i]) return i + 1;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_mul(input int u, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_res;
    int          iters;
    int          edges;
    int          own;
    logic [2:0]  exp_ctrl;
    exp_res = model_product(a, b);
    iters   = model_iters(u, a, b);
    n_checks++;
    if (req_ready[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_at_start u%0d got=%b want=1", u, req_ready[u]);
    end
    op_a[u] = a;
    op_b[u] = b;
    req_valid[u] = 1'b1;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    op_a[u] = $urandom;
    op_b[u] = $urandom;
    edges = 1;
    own = 0;
    while (!resp_valid[u] && edges < 200) begin
      n_checks++;
      if (alu_own[u]) begin
        exp_ctrl = (own % 2 == 0) ? ALU_ADD : ALU_SHL;
        if (alu_ctrl[u] !== exp_ctrl || req_ready[u] !== 1'b0 ||
            (exp_ctrl == ALU_SHL && alu_srcb[u] !== 32'd1)) begin
          n_fail++;
          $display("FAIL alu_op u%0d step=%0d ctrl=%b want=%b srcb=%h req_ready=%b",
                   u, own, alu_ctrl[u], exp_ctrl, alu_srcb[u], req_ready[u]);
        end
        own++;
      end else begin
        n_fail++;
        $display("FAIL alu_own_gap u%0d step=%0d got=0 want=1", u, own);
      end
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (!resp_valid[u]) begin
      n_fail++;
      $display("FAIL resp_timeout u%0d a=%h b=%h got_valid=0 want=1", u, a, b);
      do_reset();
      return;
    end
    n_checks++;
    if (edges != 1 + 2 * iters) begin
      n_fail++;
      $display("FAIL latency u%0d a=%h b=%h got=%0d want=%0d", u, a, b, edges, 1 + 2 * iters);
    end
    n_checks++;
    if (own != 2 * iters || alu_own[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_cycles u%0d got=%0d want=%0d own_in_done=%b", u, own, 2 * iters, alu_own[u]);
    end
    n_checks++;
    if (resp_result[u] !== exp_res) begin
      n_fail++;
      $display("FAIL result u%0d a=%h b=%h got=%h want=%h", u, a, b, resp_result[u], exp_res);
    end
    $display("mul u%0d a=%h b=%h result=%h latency=%0d", u, a, b, resp_result[u], edges);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid[u] !== 1'b1 || resp_result[u] !== exp_res || req_ready[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold u%0d cyc=%0d valid=%b result=%h want=%h req_ready=%b",
                 u, i, resp_valid[u], resp_result[u], exp_res, req_ready[u]);
      end
    end
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
    n_checks++;
    if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake u%0d valid=%b want=0 req_ready=%b want=1",
               u, resp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0 || resp_result[u] !== 32'd0 ||
          alu_own[u] !== 1'b0 || alu_srca[u] !== 32'd0 || alu_srcb[u] !== 32'd0 ||
          alu_ctrl[u] !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_state u%0d req_ready=%b valid=%b result=%h own=%b srca=%h srcb=%h ctrl=%b want 1/0/0/0/0/0/0",
                 u, req_ready[u], resp_valid[u], resp_result[u], alu_own[u],
                 alu_srca[u], alu_srcb[u], alu_ctrl[u]);
      end
    end
  endtask

  task automatic test_basic();
    do_mul(0, 32'd3, 32'd5, 0);
    do_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mul(0, 32'h0001_0000, 32'h0001_0000, 0);
  endtask

  task automatic test_zero_operand();
    do_mul(0, 32'h1234, 32'd0, 0);
    do_mul(0, 32'd0, 32'h99, 0);
    do_mul(1, 32'd0, 32'd5, 0);
  endtask

  task automatic test_full_length();
    do_mul(1, 32'd7, 32'd1, 0);
    do_mul(1, 32'hDEAD_BEEF, 32'h8000_0001, 0);
  endtask

  task automatic test_backpressure();
    do_mul(0, 32'hABCD, 32'h1F, 10);
  endtask

  task automatic test_reset_abort();
    int guard;
    op_a[0] = 32'h55;
    op_b[0] = 32'hFFFF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    guard = 0;
    while (!(alu_own[0] && alu_ctrl[0] == ALU_SHL) && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (guard >= 10) begin
      n_fail++;
      $display("FAIL abort_reach_shift got_cycles=%0d want<10", guard);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (alu_own[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_idle cyc=%0d own=%b valid=%b req_ready=%b want 0/0/1",
                 i, alu_own[0], resp_valid[0], req_ready[0]);
      end
      @(posedge clk); #1;
    end
    do_mul(0, 32'd6, 32'd7, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_mul(i % 2, $urandom, 32'(i * 3 + 1), 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) a = 32'd0;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      do_mul(int'($urandom_range(0, 1)), a, b, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    for (int u = 0; u < 2; u++) begin
      op_a[u] = '0;
      op_b[u] = '0;
    end
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_zero_operand();
    test_full_length();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
